// File: rtl/mux_2x1_stream_pkg.sv
// mux_2x1_stream_pkg: shared defaults and channel ids for the 2:1 stream merger
package mux_2x1_stream_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
endpackage

// File: rtl/mux_2x1_stream_rr_arb_2.sv
// rr_arb_2: two-requester round-robin arbiter, one-hot grant, last winner remembered
module rr_arb_2
  import mux_2x1_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_grant;
  // contested requests go to whichever channel did not win last time
  always_comb begin
    gnt = 2'b00;
    gnt = req == 2'b01 ? 2'b01 :
          req == 2'b10 ? 2'b10 :
          req == 2'b11 ? (last_grant == CH1 ? 2'b01 : 2'b10) : 2'b00;
  end
  // remember the winner of every granted cycle, contested or not
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= CH1;
    else if (en & |req) last_grant <= gnt[1];
endmodule

// File: rtl/mux_2x1_stream.sv
// mux_2x1_stream: round-robin 2:1 stream merger with registered, source-tagged output; MUX_2X1_STREAM_STATS_EN adds per-input grant counters
module mux_2x1_stream
  import mux_2x1_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  input  logic              out_ready
`ifdef MUX_2X1_STREAM_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
`endif
);
  logic       load_en;
  logic [1:0] gnt;
  logic       xfer;
  assign load_en = ~out_valid | out_ready;
  rr_arb_2 u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req({in1_valid, in0_valid}),
    .en(load_en),
    .gnt(gnt)
  );
  // readies are masked by rst_n so nothing is accepted while reset is held
  assign in0_ready = rst_n & load_en & gnt[0];
  assign in1_ready = rst_n & load_en & gnt[1];
  assign xfer = in0_ready | in1_ready;
  // output slot: load granted word, otherwise drain when the sink takes it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= CH0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= gnt[1] ? in1_data : in0_data;
      out_sel <= gnt[1] ? CH1 : CH0;
    end else if (out_ready) out_valid <= 1'b0;
`ifdef MUX_2X1_STREAM_STATS_EN
  // saturating accept counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (in0_valid & in0_ready & ~&cnt0) cnt0 <= cnt0 + CNT_W'(1);
      if (in1_valid & in1_ready & ~&cnt1) cnt1 <= cnt1 + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_mux_2x1_stream.sv
// tb_mux_2x1_stream: directed checks of reset, fairness, backpressure, single source, async reset and optional counters (MUX_2X1_STREAM_STATS_EN)
module tb_mux_2x1_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in0_data = '0, in1_data = '0;
  logic       in0_ready, in1_ready, out_valid, out_sel;
  logic [7:0] out_data;
  int checks = 0, failures = 0;
`ifdef MUX_2X1_STREAM_STATS_EN
  logic [3:0] cnt0, cnt1;
`endif
  mux_2x1_stream #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in0_valid(in0_valid),
    .in0_data(in0_data),
    .in0_ready(in0_ready),
    .in1_valid(in1_valid),
    .in1_data(in1_data),
    .in1_ready(in1_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_ready(out_ready)
`ifdef MUX_2X1_STREAM_STATS_EN
    ,
    .cnt0(cnt0),
    .cnt1(cnt1)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst_rdy0", in0_ready, 0);
    check("rst_rdy1", in1_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    check("first_rdy0", in0_ready, 1);
    check("first_rdy1", in1_ready, 0);
    for (int i = 0; i < 4; i++) begin
      in0_data = 8'h10 + 8'((i + 1) / 2);
      in1_data = 8'h20 + 8'(i / 2);
      #1;
      check("cont_rdy0", in0_ready, (i % 2 == 0) ? 1 : 0);
      check("cont_rdy1", in1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      check("cont_valid", out_valid, 1);
      check("cont_data", out_data, (i % 2 == 0) ? 32'h10 + i / 2 : 32'h20 + i / 2);
      check("cont_sel", out_sel, i % 2);
    end
    in1_valid = 1'b0;
    in0_data = 8'hA5;
    tick();
    check("bp_load", out_data, 8'hA5);
    out_ready = 1'b0;
    in0_data = 8'h30;
    in1_valid = 1'b1;
    in1_data = 8'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy0", in0_ready, 0);
      check("bp_rdy1", in1_ready, 0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 8'hA5);
      check("bp_sel", out_sel, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy1", in1_ready, 1);
    tick();
    check("bp_next_data", out_data, 8'h40);
    check("bp_next_sel", out_sel, 1);
    in1_data = 8'h41;
    tick();
    check("bp_next2_data", out_data, 8'h30);
    check("bp_next2_sel", out_sel, 0);
    in0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in1_data = 8'h50 + 8'(i);
      #1;
      check("single_rdy1", in1_ready, 1);
      tick();
      check("single_valid", out_valid, 1);
      check("single_data", out_data, 32'h50 + i);
      check("single_sel", out_sel, 1);
    end
    in0_valid = 1'b1;
    in0_data = 8'h60;
    #1;
    check("both_rdy0", in0_ready, 1);
    check("both_rdy1", in1_ready, 0);
    tick();
    check("both_data", out_data, 8'h60);
    check("both_sel", out_sel, 0);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
    check("idle_valid", out_valid, 0);
    check("idle_hold", out_data, 8'h60);
    in0_valid = 1'b1;
    in0_data = 8'h70;
    tick();
    out_ready = 1'b0;
    in1_valid = 1'b1;
    #1;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_rdy0", in0_ready, 0);
    out_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy0", in0_ready, 1);
    check("post_rst_rdy1", in1_ready, 0);
`ifdef MUX_2X1_STREAM_STATS_EN
    rst_n = 1'b0;
    #1;
    check("cnt_rst0", cnt0, 0);
    rst_n = 1'b1;
    in1_valid = 1'b0;
    in0_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("cnt0_sat", cnt0, 15);
    check("cnt1_zero", cnt1, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
